// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-addressed load/store unit in front of a word-addressed data RAM
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_dataIn,
  input  logic [31:0]       ram_dataOut,
  output logic              ram_sel,
  output logic              ram_ld,
  output logic              ram_str,
  output logic              ram_clr
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LWAIT, S_STORE, S_RESP} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wr_q;
  logic              accept, req_err;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext, merged;

  assign req_ready   = (state == S_IDLE);
  assign accept      = req_valid & req_ready;
  assign ram_clr     = ~clr_n;
  assign ram_address = addr_q[ADDR_W+1:2];
  assign ram_dataIn  = wr_q;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = req_addr[0];
      3'b010:         req_err = (req_addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
    if (req_we && req_funct3[2])
      req_err = 1'b1;
    if (req_addr[31:ADDR_W+2] != '0)
      req_err = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    ram_sel   = 1'b0;
    ram_ld    = 1'b0;
    ram_str   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                             state_nxt = S_RESP;
          else if (req_we && req_funct3 == 3'b010) state_nxt = S_STORE;
          else                                     state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        ram_sel   = 1'b1;
        ram_ld    = 1'b1;
        state_nxt = S_LWAIT;
      end
      S_LWAIT: state_nxt = we_q ? S_STORE : S_RESP;
      S_STORE: begin
        ram_sel   = 1'b1;
        ram_str   = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Little-endian lane extraction and sub-word merge over the word read in LWAIT
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = ram_dataOut[7:0];
      2'd1:    lane_b = ram_dataOut[15:8];
      2'd2:    lane_b = ram_dataOut[23:16];
      default: lane_b = ram_dataOut[31:24];
    endcase
    lane_h = addr_q[1] ? ram_dataOut[31:16] : ram_dataOut[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'd0, lane_b};
      3'b101:  load_ext = {16'd0, lane_h};
      default: load_ext = ram_dataOut;
    endcase
    merged = ram_dataOut;
    if (!f3_q[0])
      merged[{addr_q[1:0], 3'b000} +: 8] = wr_q[7:0];
    else if (addr_q[1])
      merged[31:16] = wr_q[15:0];
    else
      merged[15:0] = wr_q[15:0];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wr_q      <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q   <= req_we;
            f3_q   <= req_funct3;
            addr_q <= req_addr[ADDR_W+1:0];
            wr_q   <= req_wdata;
            if (req_err) begin
              rsp_rdata <= 32'd0;
              rsp_err   <= 1'b1;
            end
          end
        end
        S_LWAIT: begin
          if (we_q) begin
            wr_q <= merged;
          end else begin
            rsp_rdata <= load_ext;
            rsp_err   <= 1'b0;
          end
        end
        S_STORE: begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [11:0] ram_address;
  logic [31:0] ram_dataIn, ram_dataOut;
  logic        ram_sel, ram_ld, ram_str, ram_clr;

  int tests = 0;
  int fails = 0;
  int sel_cnt = 0;
  int str_cnt = 0;
  logic [31:0] last_din;
  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(12)) dut (
    .clk(clk), .clr_n(clr_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_address(ram_address), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut),
    .ram_sel(ram_sel), .ram_ld(ram_ld), .ram_str(ram_str), .ram_clr(ram_clr)
  );

  // Behavioural RAM: registered read, write on sel&str
  always @(posedge clk) begin
    if (ram_clr) begin
      ram_dataOut <= 32'd0;
    end else begin
      if (ram_sel && ram_ld) ram_dataOut <= mem[ram_address];
      if (ram_sel && ram_str) begin
        mem[ram_address] = ram_dataIn;
        last_din = ram_dataIn;
        str_cnt++;
      end
      if (ram_sel) sel_cnt++;
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_funct3 = 3'b111;
    lat = -1; rd = 32'hX; er = 1'bX;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clr_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
      fails++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0 0 0", rsp_valid, rsp_err, rsp_rdata); end
    tests++; if ({ram_sel, ram_ld, ram_str} !== 3'b000 || ram_address !== 12'd0 || ram_dataIn !== 32'd0) begin
      fails++; $display("FAIL reset_ram got s/l/w=%b%b%b a=%h d=%h want 0", ram_sel, ram_ld, ram_str, ram_address, ram_dataIn); end
    tests++; if (ram_clr !== 1'b1) begin fails++; $display("FAIL reset_clr got %b want 1", ram_clr); end
    clr_n = 1'b1;
    @(negedge clk);
    tests++; if (ram_clr !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release got clr=%b ready=%b want 0 1", ram_clr, req_ready); end
  endtask

  task automatic test_load_word;
    int lat; logic [31:0] rd; logic er;
    mem[10] = 32'h1234_1234;
    do_req(1'b0, 3'b010, 32'h28, 32'd0, lat, rd, er);
    tests++; if (lat !== 3 || rd !== 32'h1234_1234 || er !== 1'b0) begin
      fails++; $display("FAIL lw lat=%0d d=%h e=%b want 3 12341234 0", lat, rd, er); end
  endtask

  task automatic test_load_ext;
    int lat; logic [31:0] rd; logic er;
    mem[10] = 32'h8081_F0F0;
    do_req(1'b0, 3'b000, 32'h2A, 32'd0, lat, rd, er);
    tests++; if (rd !== 32'hFFFF_FF81 || er !== 1'b0 || lat !== 3) begin
      fails++; $display("FAIL lb got %h e=%b lat=%0d want ffffff81 0 3", rd, er, lat); end
    do_req(1'b0, 3'b100, 32'h2B, 32'd0, lat, rd, er);
    tests++; if (rd !== 32'h0000_0080 || er !== 1'b0) begin
      fails++; $display("FAIL lbu got %h e=%b want 00000080 0", rd, er); end
    do_req(1'b0, 3'b001, 32'h28, 32'd0, lat, rd, er);
    tests++; if (rd !== 32'hFFFF_F0F0 || er !== 1'b0) begin
      fails++; $display("FAIL lh got %h e=%b want fffff0f0 0", rd, er); end
    do_req(1'b0, 3'b101, 32'h2A, 32'd0, lat, rd, er);
    tests++; if (rd !== 32'h0000_8081 || er !== 1'b0) begin
      fails++; $display("FAIL lhu got %h e=%b want 00008081 0", rd, er); end
    do_req(1'b0, 3'b000, 32'h28, 32'd0, lat, rd, er);
    tests++; if (rd !== 32'hFFFF_FFF0) begin
      fails++; $display("FAIL lb_lane0 got %h want fffffff0", rd); end
  endtask

  task automatic test_store;
    int lat; int s0; logic [31:0] rd; logic er;
    mem[10] = 32'h1234_1234;
    s0 = str_cnt;
    do_req(1'b1, 3'b000, 32'h29, 32'hFFFF_FFAB, lat, rd, er);
    tests++; if (lat !== 4 || rd !== 32'd0 || er !== 1'b0) begin
      fails++; $display("FAIL sb_rsp lat=%0d d=%h e=%b want 4 0 0", lat, rd, er); end
    tests++; if (str_cnt - s0 !== 1 || last_din !== 32'h1234_AB34) begin
      fails++; $display("FAIL sb_write strs=%0d din=%h want 1 1234ab34", str_cnt - s0, last_din); end
    do_req(1'b0, 3'b010, 32'h28, 32'd0, lat, rd, er);
    tests++; if (rd !== 32'h1234_AB34) begin
      fails++; $display("FAIL sb_readback got %h want 1234ab34", rd); end
    do_req(1'b1, 3'b001, 32'h2A, 32'h1111_BEEF, lat, rd, er);
    tests++; if (lat !== 4 || mem[10] !== 32'hBEEF_AB34) begin
      fails++; $display("FAIL sh lat=%0d word=%h want 4 beefab34", lat, mem[10]); end
    s0 = str_cnt;
    do_req(1'b1, 3'b010, 32'h2C, 32'hCAFE_F00D, lat, rd, er);
    tests++; if (lat !== 2 || mem[11] !== 32'hCAFE_F00D || str_cnt - s0 !== 1) begin
      fails++; $display("FAIL sw lat=%0d word=%h strs=%0d want 2 cafef00d 1", lat, mem[11], str_cnt - s0); end
  endtask

  task automatic test_errors;
    int lat; int s0; logic [31:0] rd; logic er;
    s0 = sel_cnt;
    do_req(1'b0, 3'b010, 32'h2A, 32'd0, lat, rd, er);
    tests++; if (lat !== 1 || er !== 1'b1 || rd !== 32'd0) begin
      fails++; $display("FAIL lw_misalign lat=%0d e=%b d=%h want 1 1 0", lat, er, rd); end
    do_req(1'b1, 3'b001, 32'h01, 32'h1234, lat, rd, er);
    tests++; if (lat !== 1 || er !== 1'b1 || rd !== 32'd0) begin
      fails++; $display("FAIL sh_misalign lat=%0d e=%b d=%h want 1 1 0", lat, er, rd); end
    do_req(1'b0, 3'b010, 32'h4000, 32'd0, lat, rd, er);
    tests++; if (lat !== 1 || er !== 1'b1) begin
      fails++; $display("FAIL out_of_range lat=%0d e=%b want 1 1", lat, er); end
    do_req(1'b0, 3'b011, 32'h28, 32'd0, lat, rd, er);
    tests++; if (lat !== 1 || er !== 1'b1) begin
      fails++; $display("FAIL funct3_011 lat=%0d e=%b want 1 1", lat, er); end
    do_req(1'b1, 3'b100, 32'h28, 32'd0, lat, rd, er);
    tests++; if (lat !== 1 || er !== 1'b1) begin
      fails++; $display("FAIL store_bu lat=%0d e=%b want 1 1", lat, er); end
    tests++; if (sel_cnt !== s0) begin
      fails++; $display("FAIL err_no_sel sel cycles=%0d want 0", sel_cnt - s0); end
    mem[10] = 32'h1234_1234;
    do_req(1'b0, 3'b010, 32'h28, 32'd0, lat, rd, er);
    tests++; if (lat !== 3 || er !== 1'b0 || rd !== 32'h1234_1234) begin
      fails++; $display("FAIL after_err lat=%0d e=%b d=%h want 3 0 12341234", lat, er, rd); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd; logic er;
    mem[5] = 32'h0BAD_F00D;
    do_req(1'b0, 3'b010, 32'h14, 32'd0, lat, rd, er);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL ready_in_resp got %b want 0", req_ready); end
    @(negedge clk);
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL after_resp ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0) begin
      fails++; $display("FAIL rsp_hold got %h e=%b want 0badf00d 0", rsp_rdata, rsp_err); end
    do_req(1'b0, 3'b001, 32'h16, 32'd0, lat, rd, er);
    tests++; if (lat !== 3 || rd !== 32'h0000_0BAD) begin
      fails++; $display("FAIL b2b_lh lat=%0d d=%h want 3 00000bad", lat, rd); end
  endtask

  task automatic test_reset_mid_store;
    int s0; int seen;
    mem[12] = 32'h1111_1111;
    s0 = str_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    tests++; if (ram_str !== 1'b1) begin fails++; $display("FAIL store_phase str=%b want 1", ram_str); end
    clr_n = 1'b0;
    #1;
    tests++; if (ram_str !== 1'b0 || ram_sel !== 1'b0 || ram_dataIn !== 32'd0 || ram_address !== 12'd0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL abort str=%b sel=%b din=%h a=%h v=%b want 0", ram_str, ram_sel, ram_dataIn, ram_address, rsp_valid); end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    tests++; if (seen !== 0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL post_abort rsp pulses=%0d ready=%b want 0 1", seen, req_ready); end
    tests++; if (mem[12] !== 32'h1111_1111 || str_cnt !== s0) begin
      fails++; $display("FAIL abort_word got %h strs=%0d want 11111111 0", mem[12], str_cnt - s0); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    test_reset;
    test_load_word;
    test_load_ext;
    test_store;
    test_errors;
    test_back_to_back;
    test_reset_mid_store;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
